// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package seq_tx_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap,
      StDone
   } tx_state_e;

   localparam int unsigned DEF_PAT_W   = 4;
   localparam logic [3:0]  DEF_PATTERN = 4'b1101;
   localparam int unsigned DEF_GAP     = 0;
   localparam int unsigned DEF_CNT_W   = 4;
   // Gap counter width covers the 0..15 gap range
   localparam int unsigned GAP_W       = 4;

   // Even-parity bit of a pattern of up to 16 bits (zero-extended)
   function automatic logic fn_even_parity(input logic [15:0] pat);
      return ^pat;
   endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; decrement stops at zero.
module seq_down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // Load has priority over decrement; never wraps below zero
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first, repeat_cnt times,
// with GAP idle cycles between copies.
// Optional: define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit per copy.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int unsigned      PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   parameter int unsigned      GAP     = DEF_GAP,
   parameter int unsigned      CNT_W   = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_repeat_cnt,
   output logic             o_data,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_done
);

   // Index wide enough to hold PAT_W, which the parity build needs
   localparam int unsigned IDX_W = $clog2(PAT_W + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

`ifdef SEQ_PATTERN_TX_PARITY_EN
   // Index runs PAT_W..0; index 0 is the parity cycle
   localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'(PAT_W);
   localparam logic             PARITY   = fn_even_parity(16'(PATTERN));
`else
   localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'(PAT_W - 1);
`endif

   tx_state_e r_state;
   tx_state_e w_state_next;

   logic             w_idx_load, w_idx_dec, w_idx_zero;
   logic [IDX_W-1:0] w_idx;
   logic             w_gap_load, w_gap_dec, w_gap_zero;
   logic [GAP_W-1:0] w_gap_cnt;
   logic             w_rem_load, w_rem_dec, w_rem_zero;
   logic [CNT_W-1:0] w_rem_cnt;
   logic             w_bit;
   logic             w_unused_cnt;

   // Gap count value and remaining-count zero flag are not needed for control
   assign w_unused_cnt = ^{w_gap_cnt, w_rem_zero};

   seq_down_counter #(.W(IDX_W)) u_idx_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_idx_load),
      .i_load_val (IDX_LOAD),
      .i_dec      (w_idx_dec),
      .o_cnt      (w_idx),
      .o_zero     (w_idx_zero)
   );

   seq_down_counter #(.W(GAP_W)) u_gap_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_gap_load),
      .i_load_val (GAP_LOAD),
      .i_dec      (w_gap_dec),
      .o_cnt      (w_gap_cnt),
      .o_zero     (w_gap_zero)
   );

   seq_down_counter #(.W(CNT_W)) u_rem_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_rem_load),
      .i_load_val (i_repeat_cnt),
      .i_dec      (w_rem_dec),
      .o_cnt      (w_rem_cnt),
      .o_zero     (w_rem_zero)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and counter control
   always_comb begin
      w_state_next = r_state;
      w_idx_load   = 1'b0;
      w_idx_dec    = 1'b0;
      w_gap_load   = 1'b0;
      w_gap_dec    = 1'b0;
      w_rem_load   = 1'b0;
      w_rem_dec    = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_start) begin
               if (i_repeat_cnt != '0) begin
                  w_state_next = StSend;
                  w_idx_load   = 1'b1;
                  w_rem_load   = 1'b1;
               end else begin
                  w_state_next = StDone;
               end
            end
         end
         StSend: begin
            if (w_idx_zero) begin
               w_rem_dec = 1'b1;
               // rem==1 now means zero after this decrement: last copy
               if (w_rem_cnt == CNT_W'(1)) begin
                  w_state_next = StDone;
               end else if (GAP > 0) begin
                  w_state_next = StGap;
                  w_gap_load   = 1'b1;
               end else begin
                  w_idx_load = 1'b1;
               end
            end else begin
               w_idx_dec = 1'b1;
            end
         end
         StGap: begin
            if (w_gap_zero) begin
               w_state_next = StSend;
               w_idx_load   = 1'b1;
            end else begin
               w_gap_dec = 1'b1;
            end
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Current serial bit selected from the pattern by index
`ifdef SEQ_PATTERN_TX_PARITY_EN
   always_comb begin
      if (w_idx_zero) begin
         w_bit = PARITY;
      end else begin
         w_bit = |(PATTERN & (PAT_W'(1) << (w_idx - 1'b1)));
      end
   end
`else
   always_comb begin
      w_bit = |(PATTERN & (PAT_W'(1) << w_idx));
   end
`endif

   // Moore outputs decoded from state; data forced low when not valid
   always_comb begin
      o_data  = 1'b0;
      o_valid = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (r_state)
         StSend: begin
            o_data  = w_bit;
            o_valid = 1'b1;
            o_busy  = 1'b1;
         end
         StGap: begin
            o_busy = 1'b1;
         end
         StDone: begin
            o_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one instance with GAP=0, one with GAP=2.
// Event codes seen by the monitors: 0/1 = valid data bit, 2 = gap cycle, 3 = done.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [3:0] cnt_a = 4'd0;
   logic [3:0] cnt_b = 4'd0;
   logic       data_a, valid_a, busy_a, done_a;
   logic       data_b, valid_b, busy_b, done_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0] exp_a[$];
   logic [1:0] exp_b[$];

   always #5 clk = ~clk;

   seq_pattern_tx #(.GAP(0)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start_a),
      .i_repeat_cnt (cnt_a),
      .o_data       (data_a),
      .o_valid      (valid_a),
      .o_busy       (busy_a),
      .o_done       (done_a)
   );

   seq_pattern_tx #(.GAP(2)) u_dut_gap (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start_b),
      .i_repeat_cnt (cnt_b),
      .o_data       (data_b),
      .o_valid      (valid_b),
      .o_busy       (busy_b),
      .o_done       (done_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [1:0] ev_code(input logic d, input logic v, input logic b,
                                          input logic dn);
      if (dn)     return 2'd3;
      else if (v) return {1'b0, d};
      else        return 2'd2;
   endfunction

   // Monitor for the GAP=0 instance
   always @(negedge clk) begin
      if (rst) begin
         if (!valid_a) check("a_data_low_when_invalid", data_a, 0);
         if (valid_a || busy_a || done_a) begin
            if (exp_a.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL a_unexpected: got event %0d, required no event (t=%0t)",
                        ev_code(data_a, valid_a, busy_a, done_a), $time);
            end else begin
               check("a_stream", ev_code(data_a, valid_a, busy_a, done_a), exp_a.pop_front());
            end
         end
      end
   end

   // Monitor for the GAP=2 instance
   always @(negedge clk) begin
      if (rst) begin
         if (!valid_b) check("b_data_low_when_invalid", data_b, 0);
         if (valid_b || busy_b || done_b) begin
            if (exp_b.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL b_unexpected: got event %0d, required no event (t=%0t)",
                        ev_code(data_b, valid_b, busy_b, done_b), $time);
            end else begin
               check("b_stream", ev_code(data_b, valid_b, busy_b, done_b), exp_b.pop_front());
            end
         end
      end
   end

   task automatic push_ev(input bit sel_b, input logic [1:0] ev);
      if (sel_b) exp_b.push_back(ev);
      else       exp_a.push_back(ev);
   endtask

   // Expected stream for n copies of 1101 (plus parity), gaps, then done
   task automatic push_xfer(input bit sel_b, input int n);
      logic [3:0] pat;
      int         gap;
      pat = 4'b1101;
      gap = sel_b ? 2 : 0;
      for (int c = 0; c < n; c++) begin
         for (int i = 3; i >= 0; i--) push_ev(sel_b, {1'b0, pat[i]});
`ifdef SEQ_PATTERN_TX_PARITY_EN
         push_ev(sel_b, {1'b0, ^pat});
`endif
         if (c != n - 1) begin
            for (int g = 0; g < gap; g++) push_ev(sel_b, 2'd2);
         end
      end
      push_ev(sel_b, 2'd3);
   endtask

   // Wait (bounded) for both scoreboards to empty, then idle a few cycles
   task automatic drain(input string name);
      int k;
      k = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 300) begin
         @(posedge clk);
         k++;
      end
      check({name, "_drain_a"}, exp_a.size(), 0);
      check({name, "_drain_b"}, exp_b.size(), 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with start asserted: everything stays quiet
      start_a = 1'b1;
      cnt_a   = 4'd1;
      repeat (2) begin
         @(negedge clk);
         check("reset_outs_a", {data_a, valid_a, busy_a, done_a}, 0);
         check("reset_outs_b", {data_b, valid_b, busy_b, done_b}, 0);
      end
      // Single copy accepted on the first edge after release
      push_xfer(0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      @(negedge clk);
      check("latency_first_bit", {valid_a, data_a}, 2'b11);
      drain("single");

      // Three back-to-back copies; start pulse mid-transfer is ignored
      start_a = 1'b1;
      cnt_a   = 4'd3;
      push_xfer(0, 3);
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      start_a = 1'b1;
      cnt_a   = 4'd5;
      @(posedge clk);
      #1 start_a = 1'b0;
      drain("b2b");

      // start held high: second transfer begins on the IDLE cycle after DONE
      start_a = 1'b1;
      cnt_a   = 4'd1;
      push_xfer(0, 1);
      push_xfer(0, 1);
`ifdef SEQ_PATTERN_TX_PARITY_EN
      repeat (10) @(posedge clk);
`else
      repeat (8) @(posedge clk);
`endif
      #1 start_a = 1'b0;
      drain("held");

      // Zero count: done on the cycle after acceptance, no data
      start_a = 1'b1;
      cnt_a   = 4'd0;
      push_ev(0, 2'd3);
      @(posedge clk);
      #1 start_a = 1'b0;
      @(negedge clk);
      check("zero_cnt_done", {done_a, valid_a, busy_a}, 3'b100);
      drain("zero");

      // Gap instance: 1101,gap,gap,1101,done
      start_b = 1'b1;
      cnt_b   = 4'd2;
      push_xfer(1, 2);
      @(posedge clk);
      #1 start_b = 1'b0;
      drain("gap");

      // Maximum repeat count
      start_a = 1'b1;
      cnt_a   = 4'd15;
      push_xfer(0, 15);
      @(posedge clk);
      #1 start_a = 1'b0;
      drain("max_cnt");

      // Reset during the second bit aborts asynchronously, no done pulse
      start_a = 1'b1;
      cnt_a   = 4'd1;
      push_ev(0, 2'd1);
      @(posedge clk);
      #1 start_a = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_reset_outs", {data_a, valid_a, busy_a, done_a}, 0);
      exp_a.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start_a = 1'b1;
      push_xfer(0, 1);
      @(posedge clk);
      #1 start_a = 1'b0;
      @(negedge clk);
      check("restart_first_bit", {valid_a, data_a}, 2'b11);
      drain("restart");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter, the source end of the serial sequence-detection path. On a start request it shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clock, and repeats it a requested number of times with an optional idle gap between copies. It drives stimulus into the team's Moore sequence detectors, for example the 1101 non-overlapping detector `moore`, and acts as a reusable on-chip traffic source.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
PATTERN, 4'b1101, pattern sent MSB-first
GAP, 0, idle cycles inserted between consecutive copies (0..15)
CNT_W, 4, width of the repeat count

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-low; the block is in reset while rst=0
start  input  1  transmit request; sampled only in IDLE
repeat_cnt  input  CNT_W  number of pattern copies; captured when start is accepted
data  output  1  serial bit out
valid  output  1  high when data carries a pattern or parity bit
busy  output  1  high from the cycle after start acceptance until the DONE state
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, data=0, valid=0, busy=0, done=0, bit index=0, remaining count=0.
- Outputs are Moore-style: registered and derived only from state and counters, never combinationally from start.
- States:
  - IDLE: if start=1 and repeat_cnt!=0, capture repeat_cnt into rem and go to SEND with bit index=PAT_W-1. If start=1 and repeat_cnt=0, go to DONE.
  - SEND: data=PATTERN[idx], valid=1, busy=1. idx decrements each cycle. When idx=0, decrement rem. Then:
    - rem (after decrement) = 0: go to DONE.
    - else GAP>0: go to GAP.
    - else: go to SEND with idx=PAT_W-1.
  - GAP: data=0, valid=0, busy=1 for exactly GAP cycles, then SEND with idx=PAT_W-1.
  - DONE: done=1, busy=0, valid=0, data=0 for one cycle, then IDLE.
- Latency: the first pattern bit appears on data in the cycle after the rising edge that accepted start.
- Total active cycles for N copies: N*PAT_W + (N-1)*GAP.
- start is ignored outside IDLE; there is no queuing.
- start held high continuously: a new transfer is accepted on the IDLE cycle following DONE.
- The repeat count saturates at its maximum 2^CNT_W-1; there is no wrap.
- Reset mid-transfer aborts immediately. Outputs go to their reset values asynchronously, and no done pulse is produced.
- data=0 whenever valid=0.

Optional Feature:
- Macro: SEQ_PATTERN_TX_PARITY_EN.
- Defined: after each copy's last pattern bit, one extra SEND-class cycle drives the even-parity bit (XOR of PATTERN) with valid=1, before the gap or DONE. Per-copy length becomes PAT_W+1.
- Undefined: no parity cycle; behaviour as above.

Decomposition:
- Package seq_tx_pkg holds:
  - state typedef (IDLE, SEND, GAP, DONE)
  - default pattern constant 4'b1101
  - default widths
- One natural sub-module: seq_down_counter, a loadable down-counter with a zero flag. It is instantiated for the bit index, the gap count and the repeat count.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 → data=0, valid=0, busy=0, done=0 throughout; no transfer begins until rst=1.
- Single copy: start=1 for one cycle with repeat_cnt=1 → data=1,1,0,1 with valid=1 on the 4 cycles after acceptance, then done=1 for one cycle, then IDLE.
- Back-to-back loopback into `moore`: repeat_cnt=3, GAP=0 → data stream 110111011101; the detector asserts detected 3 times, once after each copy.
- Gap: GAP=2, repeat_cnt=2 → 1101,0,0,1101 with valid=0 on the two gap cycles; done asserts 10 cycles after the first bit.
- Zero count and ignored start: repeat_cnt=0 → done pulses on the cycle after acceptance with valid never set. Pulsing start mid-transfer has no effect on the stream.
- Mid-transfer reset: rst=0 during the 2nd bit → outputs drop immediately; after release, a new start transmits a complete 1101 from its first bit.
- With SEQ_PATTERN_TX_PARITY_EN defined: repeat_cnt=1 → 1101 followed by parity bit 1.
